mem_arbiter: RTL and testbench

- Sequences the single shared RAM port between the instruction and data caches of CPUS cores.
- Sits between the per-core icache/dcache miss ports and the RAM model.
- Accepts at most one transaction at a time and drives it to completion on RAM.
- Returns the data and a one-cycle wait release to the granted requester.

---
 rtl/mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between the icache/dcache miss ports of CPUS cores.
// One transaction at a time: IDLE picks a winner, ACCESS runs it on RAM, RESP pulses its wait low.
// Ports:
//   CLK, RST               clock, synchronous active-high reset
//   iREN/iaddr             per-core instruction read request and address
//   iwait/iload            per-core instruction wait (low one cycle) and read data
//   dREN/dWEN/daddr/dstore per-core data read/write request, address, store value
//   dwait/dload            per-core data wait (low one cycle) and read data
//   ram_ren/ram_wen        RAM read/write strobes
//   ram_addr/ram_store     RAM address and write data
//   ram_load/ram_ready     RAM read data and access-complete flag
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin between cores;
// otherwise the lowest-numbered requesting core wins.
module mem_arbiter #(
    parameter int CPUS = 2,
    parameter int AW   = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [CPUS-1:0]    iREN,
    input  logic [AW*CPUS-1:0] iaddr,
    output logic [CPUS-1:0]    iwait,
    output logic [AW*CPUS-1:0] iload,
    input  logic [CPUS-1:0]    dREN,
    input  logic [CPUS-1:0]    dWEN,
    input  logic [AW*CPUS-1:0] daddr,
    input  logic [AW*CPUS-1:0] dstore,
    output logic [CPUS-1:0]    dwait,
    output logic [AW*CPUS-1:0] dload,
    output logic               ram_ren,
    output logic               ram_wen,
    output logic [AW-1:0]      ram_addr,
    output logic [AW-1:0]      ram_store,
    input  logic [AW-1:0]      ram_load,
    input  logic               ram_ready
);

    localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]         r_state;
    logic [CW-1:0]      r_core;
    logic               r_data;
    logic               r_ren;
    logic               r_wen;
    logic [AW-1:0]      r_addr;
    logic [AW-1:0]      r_store;
    logic [CPUS-1:0]    r_iwait;
    logic [CPUS-1:0]    r_dwait;
    logic [AW*CPUS-1:0] r_iload;
    logic [AW*CPUS-1:0] r_dload;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [CW-1:0]      r_ptr;
`endif

    logic [CPUS-1:0]    w_dreq;
    logic [CPUS-1:0]    w_req;
    logic               w_use_d;
    logic               w_any;
    logic [CW-1:0]      w_win;
    logic               w_wr;
    logic [AW-1:0]      w_addr;
    logic [AW-1:0]      w_store;

    // Data requests of any core shadow all instruction requests.
    always_comb begin
        w_dreq  = dREN | dWEN;
        w_use_d = |w_dreq;
        w_req   = w_use_d ? w_dreq : iREN;
        w_any   = |w_req;
    end

    // First requesting core scanning upward from the start point, with wrap.
    always_comb begin
        logic found;
        int   j;
        found = 1'b0;
        w_win = '0;
        for (int k = 0; k < CPUS; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            j = int'(r_ptr) + k;
            if (j >= CPUS) j = j - CPUS;
`else
            j = k;
`endif
            if (!found && w_req[j]) begin
                found = 1'b1;
                w_win = CW'(j);
            end
        end
    end

    // Winner's address/store; a write whenever dWEN is set, even with dREN.
    always_comb begin
        w_wr    = 1'b0;
        w_addr  = '0;
        w_store = '0;
        for (int n = 0; n < CPUS; n++) begin
            if (w_win == CW'(n)) begin
                w_addr  = w_use_d ? daddr[n*AW +: AW] : iaddr[n*AW +: AW];
                w_store = dstore[n*AW +: AW];
                w_wr    = w_use_d && dWEN[n];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_core  <= '0;
            r_data  <= 1'b0;
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_store <= '0;
            r_iwait <= '1;
            r_dwait <= '1;
            r_iload <= '0;
            r_dload <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_ptr   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_core  <= w_win;
                        r_data  <= w_use_d;
                        r_addr  <= w_addr;
                        r_store <= w_store;
                        r_ren   <= !w_wr;
                        r_wen   <= w_wr;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (ram_ready) begin
                        for (int n = 0; n < CPUS; n++) begin
                            if (r_core == CW'(n)) begin
                                if (r_data) begin
                                    if (r_ren) r_dload[n*AW +: AW] <= ram_load;
                                    r_dwait[n] <= 1'b0;
                                end else begin
                                    r_iload[n*AW +: AW] <= ram_load;
                                    r_iwait[n] <= 1'b0;
                                end
                            end
                        end
                        r_ren   <= 1'b0;
                        r_wen   <= 1'b0;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_iwait <= '1;
                    r_dwait <= '1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    r_ptr   <= (r_core == CW'(CPUS - 1)) ? '0 : r_core + 1'b1;
`endif
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign iwait     = r_iwait;
    assign dwait     = r_dwait;
    assign iload     = r_iload;
    assign dload     = r_dload;
    assign ram_ren   = r_ren;
    assign ram_wen   = r_wen;
    assign ram_addr  = r_addr;
    assign ram_store = r_store;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random and directed stimulus against a transaction-level model.
// Checks strobes, address/store, wait pulses and load slices every cycle.
module tb_mem_arbiter;

    localparam int CPUS = 2;
    localparam int AW   = 32;

    logic               CLK;
    logic               RST;
    logic [CPUS-1:0]    iREN;
    logic [AW*CPUS-1:0] iaddr;
    logic [CPUS-1:0]    iwait;
    logic [AW*CPUS-1:0] iload;
    logic [CPUS-1:0]    dREN;
    logic [CPUS-1:0]    dWEN;
    logic [AW*CPUS-1:0] daddr;
    logic [AW*CPUS-1:0] dstore;
    logic [CPUS-1:0]    dwait;
    logic [AW*CPUS-1:0] dload;
    logic               ram_ren;
    logic               ram_wen;
    logic [AW-1:0]      ram_addr;
    logic [AW-1:0]      ram_store;
    logic [AW-1:0]      ram_load;
    logic               ram_ready;

    mem_arbiter #(.CPUS(CPUS), .AW(AW)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ram_ren(ram_ren), .ram_wen(ram_wen),
        .ram_addr(ram_addr), .ram_store(ram_store),
        .ram_load(ram_load), .ram_ready(ram_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: at most one outstanding transaction, then one response cycle.
    bit            m_busy;
    bit            m_resp;
    bit            m_fresh;
    int            m_win;
    bit            m_data;
    bit            m_wr;
    logic [AW-1:0] m_addr;
    logic [AW-1:0] m_store;
    int            m_ptr;
    logic [AW-1:0] m_iload [CPUS];
    logic [AW-1:0] m_dload [CPUS];
    int            n_grants [CPUS];

    task automatic model_reset();
        m_busy  = 0;
        m_resp  = 0;
        m_fresh = 1;
        m_ptr   = 0;
        for (int n = 0; n < CPUS; n++) begin
            m_iload[n] = '0;
            m_dload[n] = '0;
        end
    endtask

    task automatic model_step();
        bit req [CPUS];
        bit use_d;
        int start;
        int c;
        if (RST) begin
            model_reset();
            return;
        end
        if (m_resp) begin
            m_resp = 0;
            m_ptr  = (m_win + 1) % CPUS;
            return;
        end
        if (m_busy) begin
            if (ram_ready) begin
                if (!m_wr) begin
                    if (m_data) m_dload[m_win] = ram_load;
                    else        m_iload[m_win] = ram_load;
                end
                m_busy = 0;
                m_resp = 1;
            end
            return;
        end
        use_d = ((dREN | dWEN) != '0);
        for (int n = 0; n < CPUS; n++)
            req[n] = use_d ? (dREN[n] | dWEN[n]) : iREN[n];
`ifdef MEM_ARB_ROUND_ROBIN_EN
        start = m_ptr;
`else
        start = 0;
`endif
        for (int k = 0; k < CPUS; k++) begin
            c = (start + k) % CPUS;
            if (req[c] && !m_busy) begin
                m_busy  = 1;
                m_fresh = 0;
                m_win   = c;
                m_data  = use_d;
                m_wr    = use_d && dWEN[c];
                m_addr  = use_d ? daddr[c*AW +: AW] : iaddr[c*AW +: AW];
                m_store = dstore[c*AW +: AW];
                n_grants[c]++;
            end
        end
    endtask

    task automatic check_outputs();
        logic [CPUS-1:0]    ew_i;
        logic [CPUS-1:0]    ew_d;
        logic [AW*CPUS-1:0] el_i;
        logic [AW*CPUS-1:0] el_d;
        ew_i = '1;
        ew_d = '1;
        if (m_resp) begin
            if (m_data) ew_d[m_win] = 1'b0;
            else        ew_i[m_win] = 1'b0;
        end
        for (int n = 0; n < CPUS; n++) begin
            el_i[n*AW +: AW] = m_iload[n];
            el_d[n*AW +: AW] = m_dload[n];
        end
        check("ram_ren", 128'(ram_ren), 128'(m_busy && !m_wr));
        check("ram_wen", 128'(ram_wen), 128'(m_busy && m_wr));
        check("iwait", 128'(iwait), 128'(ew_i));
        check("dwait", 128'(dwait), 128'(ew_d));
        check("iload", 128'(iload), 128'(el_i));
        check("dload", 128'(dload), 128'(el_d));
        if (m_busy) check("ram_addr", 128'(ram_addr), 128'(m_addr));
        if (m_busy && m_wr) check("ram_store", 128'(ram_store), 128'(m_store));
        if (m_fresh) begin
            check("ram_addr_rst", 128'(ram_addr), 128'(0));
            check("ram_store_rst", 128'(ram_store), 128'(0));
        end
    endtask

    task automatic cycle(input logic rst, input logic [CPUS-1:0] ir,
                         input logic [CPUS-1:0] dr, input logic [CPUS-1:0] dw,
                         input logic rdy);
        @(negedge CLK);
        check_outputs();
        RST       = rst;
        iREN      = ir;
        dREN      = dr;
        dWEN      = dw;
        ram_ready = rdy;
        ram_load  = $urandom;
        for (int n = 0; n < CPUS; n++) begin
            iaddr[n*AW +: AW]  = $urandom;
            daddr[n*AW +: AW]  = $urandom;
            dstore[n*AW +: AW] = $urandom;
        end
        model_step();
    endtask

    function automatic logic [CPUS-1:0] rbits(input int pct);
        logic [CPUS-1:0] v;
        for (int n = 0; n < CPUS; n++) v[n] = ($urandom_range(0, 99) < pct);
        return v;
    endfunction

    initial begin
        RST = 1'b1; iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        ram_load = '0; ram_ready = 1'b0;
        model_reset();
        for (int n = 0; n < CPUS; n++) n_grants[n] = 0;
        repeat (2) @(posedge CLK);

        repeat (2) cycle(1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        repeat (5) cycle(1'b0, 2'b00, 2'b00, 2'b00, 1'b1);

        cycle(1'b0, 2'b01, 2'b00, 2'b00, 1'b0);
        repeat (2) cycle(1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        repeat (4) cycle(1'b0, 2'b00, 2'b00, 2'b00, 1'b1);

        cycle(1'b0, 2'b01, 2'b00, 2'b10, 1'b0);
        cycle(1'b0, 2'b01, 2'b00, 2'b00, 1'b1);
        repeat (6) cycle(1'b0, 2'b00, 2'b00, 2'b00, 1'b1);

        for (int n = 0; n < CPUS; n++) n_grants[n] = 0;
        repeat (12) cycle(1'b0, 2'b00, 2'b11, 2'b00, 1'b1);
        repeat (3) cycle(1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        check("rr_core1_grants", 128'(n_grants[1]), 128'(n_grants[0]));
`else
        check("fixed_core1_grants", 128'(n_grants[1]), 128'(0));
`endif

        cycle(1'b0, 2'b00, 2'b10, 2'b00, 1'b0);
        cycle(1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        repeat (4) cycle(1'b0, 2'b00, 2'b00, 2'b00, 1'b1);

        cycle(1'b0, 2'b00, 2'b01, 2'b00, 1'b0);
        cycle(1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        cycle(1'b1, 2'b00, 2'b00, 2'b00, 1'b1);
        repeat (4) cycle(1'b0, 2'b00, 2'b00, 2'b00, 1'b1);

        for (int t = 0; t < 3000; t++)
            cycle(($urandom_range(0, 249) == 0), rbits(30), rbits(20),
                  rbits(15), ($urandom_range(0, 99) < 45));

        @(negedge CLK);
        check_outputs();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
